lc3_controller: RTL and testbench
=================================

# lc3_controller

Multi-cycle FSM that sequences the LC-3 datapath through fetch, decode and execute. It drives every datapath control strobe and register-select field. It takes the instruction register and N/Z/P flags back from the datapath. It waits on a memory ready handshake for every read, and enters a sticky halt on any unsupported opcode.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- IR  in  16  instruction register from datapath
- N, Z, P  in  1 each  condition flags from datapath
- mem_rdy  in  1  memory read data on data_out valid this cycle
- ldMAR, ldMDR, selMDR, ldIR, ldPC, regWE, flagWE  out  1  datapath load/write strobes
- enaPC, enaMDR, enaALU, enaMARM  out  1  bus driver enables
- selEAB1, selMAR  out  1  EAB base select (0=PC, 1=SR1) and MARM select (0=EAB, 1=zext IR[7:0])
- selPC, selEAB2, aluControl  out  2 each  PC source (0=PC+1, 1=EAB, 2=bus), offset select (0=0, 1=sext IR[5:0], 2=sext IR[8:0], 3=sext IR[10:0]), ALU op (0=ADD, 1=AND, 2=NOT)
- SR1, SR2, DR  out  3 each  register file selects
- halted  out  1  high in HALT state

## Operation
States: FETCH0, FETCH1, FETCH2, DECODE, ALU, BR, JMP, LEA, ADDR, MEMRD, IND, MEMRD2, LOADREG, HALT.

Default for every output not listed in a state is 0. SR1, SR2 and DR are driven continuously from IR in every state: SR1=IR[8:6], SR2=IR[2:0], DR=IR[11:9]. aluControl is driven continuously: ADD for opcode 0001, AND for 0101, NOT otherwise.

Per-state outputs and transitions:
- FETCH0: enaPC, ldMAR, ldPC with selPC=0. MAR gets the old PC. -> FETCH1.
- FETCH1: if mem_rdy, ldMDR with selMDR=1 -> FETCH2. Else stay.
- FETCH2: enaMDR, ldIR -> DECODE.
- DECODE: no strobes. Dispatch on IR[15:12]:
  - 0001, 0101, 1001 -> ALU
  - 0000 -> BR
  - 1100 -> JMP
  - 1110 -> LEA
  - 0010, 0110, 1010 -> ADDR
  - all others -> HALT
- ALU: enaALU, regWE, flagWE -> FETCH0.
- BR: selEAB1=0, selEAB2=2, selPC=1. ldPC only if (IR[11]&N)|(IR[10]&Z)|(IR[9]&P). -> FETCH0.
- JMP: selEAB1=1, selEAB2=0, selPC=1, ldPC -> FETCH0.
- LEA: selEAB1=0, selEAB2=2, selMAR=0, enaMARM, regWE, flagWE -> FETCH0.
- ADDR: enaMARM, selMAR=0, ldMAR. LD (0010) and LDI (1010) use selEAB1=0, selEAB2=2. LDR (0110) uses selEAB1=1, selEAB2=1. -> MEMRD.
- MEMRD: as FETCH1. On mem_rdy -> IND if opcode is 1010, else LOADREG.
- IND: enaMDR, ldMAR -> MEMRD2.
- MEMRD2: as FETCH1. On mem_rdy -> LOADREG.
- LOADREG: enaMDR, regWE, flagWE -> FETCH0.
- HALT: all strobes 0, halted=1. Exit only by reset.

Invariants:
- At most one of enaPC, enaMDR, enaALU, enaMARM is high in any cycle.
- ldMDR is never high without selMDR=1.
- PC-relative offsets apply to the already-incremented PC.

## Timing
- rst high: state forced to FETCH0 asynchronously. While rst is high, all outputs are gated to 0, including halted. First FETCH0 strobes appear in the first cycle after rst deasserts.
- mem_rdy is sampled combinationally in FETCH1, MEMRD and MEMRD2. ldMDR is a same-cycle (Mealy) response. Each extra cycle of mem_rdy low adds one cycle.
- Zero-wait latency, counted FETCH0 to the next FETCH0:
  - ALU, BR, JMP, LEA: 5 cycles
  - LD, LDR: 7 cycles
  - LDI: 9 cycles
- Reset in any state, including mid-read: immediate return to FETCH0. No strobe is held past the reset edge.
- mem_rdy high outside the read states is ignored.
- BR with IR[11:9]=000 is a 5-cycle NOP.

## Test plan
- Reset, then IR=0x1265 (ADD R1,R1,#5), mem_rdy tied 1 -> FETCH0 strobes in cycle 1. Cycle 5 shows enaALU=regWE=flagWE=1, DR=1, SR1=1, aluControl=0. Cycle 6 is back in FETCH0.
- IR=0x0405 (BRz +5): Z=1 -> ldPC=1, selPC=1, selEAB2=2 in BR. Repeat with Z=0 -> ldPC=0 in BR.
- IR=0x6642 (LDR R3,R1,#2), mem_rdy low for 3 cycles in MEMRD -> MEMRD held 4 cycles with ldMDR only on the last. ADDR shows selEAB1=1, selEAB2=1. LOADREG shows DR=3 with enaMDR and regWE.
- IR=0xA002 (LDI R0,#2), mem_rdy=1 -> state sequence ADDR, MEMRD, IND, MEMRD2, LOADREG; ldMAR asserted in ADDR and IND; 9-cycle total.
- IR=0xF025 (TRAP, unsupported) -> HALT after DECODE. halted=1 with all strobes 0 for 20+ cycles. rst clears halted.
- Assert rst in MEMRD while mem_rdy=0 -> outputs 0 immediately. After release, FETCH0 with enaPC=ldMAR=ldPC=1. Every cycle of every test is checked for one-hot-or-zero bus enables.

Source files
------------

// File: rtl/lc3_controller.sv
// rtl/lc3_controller.sv - LC-3 multi-cycle fetch/decode/execute control FSM
module lc3_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IR,
  input  logic        N,
  input  logic        Z,
  input  logic        P,
  input  logic        mem_rdy,
  output logic        ldMAR,
  output logic        ldMDR,
  output logic        selMDR,
  output logic        ldIR,
  output logic        ldPC,
  output logic        regWE,
  output logic        flagWE,
  output logic        enaPC,
  output logic        enaMDR,
  output logic        enaALU,
  output logic        enaMARM,
  output logic        selEAB1,
  output logic        selMAR,
  output logic [1:0]  selPC,
  output logic [1:0]  selEAB2,
  output logic [1:0]  aluControl,
  output logic [2:0]  SR1,
  output logic [2:0]  SR2,
  output logic [2:0]  DR,
  output logic        halted
);

  typedef enum logic [3:0] {
    FETCH0, FETCH1, FETCH2, DECODE, ALU, BR, JMP, LEA,
    ADDR, MEMRD, IND, MEMRD2, LOADREG, HALT
  } state_t;

  state_t state, next;
  logic [3:0] op;
  logic br_taken;
  logic unused_ir;

  assign op        = IR[15:12];
  assign br_taken  = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
  assign unused_ir = ^IR[5:3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH0;
    else     state <= next;
  end

  always_comb begin
    next       = state;
    ldMAR      = 1'b0;
    ldMDR      = 1'b0;
    selMDR     = 1'b0;
    ldIR       = 1'b0;
    ldPC       = 1'b0;
    regWE      = 1'b0;
    flagWE     = 1'b0;
    enaPC      = 1'b0;
    enaMDR     = 1'b0;
    enaALU     = 1'b0;
    enaMARM    = 1'b0;
    selEAB1    = 1'b0;
    selMAR     = 1'b0;
    selPC      = 2'd0;
    selEAB2    = 2'd0;
    halted     = 1'b0;
    SR1        = IR[8:6];
    SR2        = IR[2:0];
    DR         = IR[11:9];
    case (op)
      4'b0001: aluControl = 2'd0;
      4'b0101: aluControl = 2'd1;
      default: aluControl = 2'd2;
    endcase

    case (state)
      FETCH0: begin
        enaPC = 1'b1;
        ldMAR = 1'b1;
        ldPC  = 1'b1;
        next  = FETCH1;
      end
      FETCH1, MEMRD, MEMRD2: begin
        // Mealy response: the read completes in the same cycle mem_rdy is seen
        if (mem_rdy) begin
          ldMDR  = 1'b1;
          selMDR = 1'b1;
          case (state)
            FETCH1:  next = FETCH2;
            MEMRD:   next = (op == 4'b1010) ? IND : LOADREG;
            default: next = LOADREG;
          endcase
        end
      end
      FETCH2: begin
        enaMDR = 1'b1;
        ldIR   = 1'b1;
        next   = DECODE;
      end
      DECODE: begin
        case (op)
          4'b0001, 4'b0101, 4'b1001: next = ALU;
          4'b0000:                   next = BR;
          4'b1100:                   next = JMP;
          4'b1110:                   next = LEA;
          4'b0010, 4'b0110, 4'b1010: next = ADDR;
          default:                   next = HALT;
        endcase
      end
      ALU: begin
        enaALU = 1'b1;
        regWE  = 1'b1;
        flagWE = 1'b1;
        next   = FETCH0;
      end
      BR: begin
        selEAB2 = 2'd2;
        selPC   = 2'd1;
        ldPC    = br_taken;
        next    = FETCH0;
      end
      JMP: begin
        selEAB1 = 1'b1;
        selPC   = 2'd1;
        ldPC    = 1'b1;
        next    = FETCH0;
      end
      LEA: begin
        selEAB2 = 2'd2;
        enaMARM = 1'b1;
        regWE   = 1'b1;
        flagWE  = 1'b1;
        next    = FETCH0;
      end
      ADDR: begin
        enaMARM = 1'b1;
        ldMAR   = 1'b1;
        // LDR is base+offset6; LD and LDI are PC-relative offset9
        if (op == 4'b0110) begin
          selEAB1 = 1'b1;
          selEAB2 = 2'd1;
        end else begin
          selEAB2 = 2'd2;
        end
        next = MEMRD;
      end
      IND: begin
        enaMDR = 1'b1;
        ldMAR  = 1'b1;
        next   = MEMRD2;
      end
      LOADREG: begin
        enaMDR = 1'b1;
        regWE  = 1'b1;
        flagWE = 1'b1;
        next   = FETCH0;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: next = FETCH0;
    endcase

    if (rst) begin
      ldMAR      = 1'b0;
      ldMDR      = 1'b0;
      selMDR     = 1'b0;
      ldIR       = 1'b0;
      ldPC       = 1'b0;
      regWE      = 1'b0;
      flagWE     = 1'b0;
      enaPC      = 1'b0;
      enaMDR     = 1'b0;
      enaALU     = 1'b0;
      enaMARM    = 1'b0;
      selEAB1    = 1'b0;
      selMAR     = 1'b0;
      selPC      = 2'd0;
      selEAB2    = 2'd0;
      aluControl = 2'd0;
      SR1        = 3'd0;
      SR2        = 3'd0;
      DR         = 3'd0;
      halted     = 1'b0;
    end
  end

endmodule

// File: tb/tb_lc3_controller.sv
// tb/tb_lc3_controller.sv - scoreboard bench for lc3_controller
module tb_lc3_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] IR = 16'h0000;
  logic        N = 1'b0, Z = 1'b0, P = 1'b0;
  logic        mem_rdy = 1'b0;
  logic        ldMAR, ldMDR, selMDR, ldIR, ldPC, regWE, flagWE;
  logic        enaPC, enaMDR, enaALU, enaMARM, selEAB1, selMAR, halted;
  logic [1:0]  selPC, selEAB2, aluControl;
  logic [2:0]  SR1, SR2, DR;

  lc3_controller dut (
    .clk(clk), .rst(rst), .IR(IR), .N(N), .Z(Z), .P(P), .mem_rdy(mem_rdy),
    .ldMAR(ldMAR), .ldMDR(ldMDR), .selMDR(selMDR), .ldIR(ldIR), .ldPC(ldPC),
    .regWE(regWE), .flagWE(flagWE), .enaPC(enaPC), .enaMDR(enaMDR),
    .enaALU(enaALU), .enaMARM(enaMARM), .selEAB1(selEAB1), .selMAR(selMAR),
    .selPC(selPC), .selEAB2(selEAB2), .aluControl(aluControl),
    .SR1(SR1), .SR2(SR2), .DR(DR), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic ld_mar, ld_mdr, sel_mdr, ld_ir, ld_pc, reg_we, flag_we;
    logic ena_pc, ena_mdr, ena_alu, ena_marm, sel_eab1, sel_mar;
    logic [1:0] sel_pc, sel_eab2, alu;
    logic [2:0] sr1, sr2, dr;
    logic halted;
  } obs_t;

  typedef struct {
    obs_t exp;
    logic rdy;
    int   st;
  } sb_t;

  localparam int S_F0 = 0, S_F1 = 1, S_F2 = 2, S_DEC = 3, S_ALU = 4, S_BR = 5,
                 S_JMP = 6, S_LEA = 7, S_ADDR = 8, S_MR = 9, S_IND = 10,
                 S_MR2 = 11, S_LDREG = 12, S_HALT = 13;
  string names [14] = '{"FETCH0", "FETCH1", "FETCH2", "DECODE", "ALU", "BR", "JMP",
                        "LEA", "ADDR", "MEMRD", "IND", "MEMRD2", "LOADREG", "HALT"};

  sb_t  sb[$];
  sb_t  e;
  obs_t o;
  obs_t ex;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic obs_t observe();
    obs_t r;
    r.ld_mar = ldMAR;   r.ld_mdr = ldMDR;     r.sel_mdr = selMDR;  r.ld_ir = ldIR;
    r.ld_pc = ldPC;     r.reg_we = regWE;     r.flag_we = flagWE;  r.ena_pc = enaPC;
    r.ena_mdr = enaMDR; r.ena_alu = enaALU;   r.ena_marm = enaMARM;
    r.sel_eab1 = selEAB1; r.sel_mar = selMAR; r.sel_pc = selPC;    r.sel_eab2 = selEAB2;
    r.alu = aluControl; r.sr1 = SR1; r.sr2 = SR2; r.dr = DR;       r.halted = halted;
    return r;
  endfunction

  function automatic logic onehot0(obs_t v);
    return ($countones({v.ena_pc, v.ena_mdr, v.ena_alu, v.ena_marm}) <= 1);
  endfunction

  // Reference outputs for one cycle in a given state, built from the state table
  function automatic obs_t exp_state(int st, logic [15:0] ir, logic n, logic z, logic p, logic rdy);
    obs_t r = '0;
    r.sr1 = ir[8:6];
    r.sr2 = ir[2:0];
    r.dr  = ir[11:9];
    r.alu = (ir[15:12] == 4'b0001) ? 2'd0 : (ir[15:12] == 4'b0101) ? 2'd1 : 2'd2;
    case (st)
      S_F0: begin r.ena_pc = 1; r.ld_mar = 1; r.ld_pc = 1; end
      S_F1, S_MR, S_MR2: if (rdy) begin r.ld_mdr = 1; r.sel_mdr = 1; end
      S_F2: begin r.ena_mdr = 1; r.ld_ir = 1; end
      S_ALU: begin r.ena_alu = 1; r.reg_we = 1; r.flag_we = 1; end
      S_BR: begin
        r.sel_eab2 = 2; r.sel_pc = 1;
        r.ld_pc = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
      end
      S_JMP: begin r.sel_eab1 = 1; r.sel_pc = 1; r.ld_pc = 1; end
      S_LEA: begin r.sel_eab2 = 2; r.ena_marm = 1; r.reg_we = 1; r.flag_we = 1; end
      S_ADDR: begin
        r.ena_marm = 1; r.ld_mar = 1;
        if (ir[15:12] == 4'b0110) begin r.sel_eab1 = 1; r.sel_eab2 = 1; end
        else r.sel_eab2 = 2;
      end
      S_IND: begin r.ena_mdr = 1; r.ld_mar = 1; end
      S_LDREG: begin r.ena_mdr = 1; r.reg_we = 1; r.flag_we = 1; end
      S_HALT: r.halted = 1;
      default: ;
    endcase
    return r;
  endfunction

  task automatic push(int st, logic rdy);
    sb_t s;
    s.exp = exp_state(st, IR, N, Z, P, rdy);
    s.rdy = rdy;
    s.st  = st;
    sb.push_back(s);
  endtask

  task automatic apply_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_reset();
    IR = 16'h1265; mem_rdy = 1'b1; rst = 1'b1;
    @(negedge clk); #1;
    o = observe(); vectors++;
    if (o !== '0) begin
      miscompares++; $display("FAIL reset_outputs: got %h want %h", o, obs_t'('0));
    end
  endtask

  task automatic test_alu();
    IR = 16'h1265;
    apply_reset();
    push(S_F0, 1); push(S_F1, 1); push(S_F2, 1); push(S_DEC, 1); push(S_ALU, 1); push(S_F0, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); mem_rdy = e.rdy; #1;
      o = observe(); vectors++;
      if (o !== e.exp) begin
        miscompares++; $display("FAIL alu %s: got %h want %h", names[e.st], o, e.exp);
      end
      vectors++;
      if (!onehot0(o)) begin miscompares++; $display("FAIL alu bus_enables: got %h want one-hot-or-zero", o); end
      @(negedge clk);
    end
  endtask

  task automatic test_br();
    for (int k = 0; k < 3; k++) begin
      IR = (k == 2) ? 16'h0005 : 16'h0405;
      Z  = (k == 0);
      N  = (k == 2);
      P  = (k == 2);
      apply_reset();
      push(S_F0, 1); push(S_F1, 1); push(S_F2, 1); push(S_DEC, 1); push(S_BR, 1); push(S_F0, 1);
      while (sb.size() > 0) begin
        e = sb.pop_front(); mem_rdy = e.rdy; #1;
        o = observe(); vectors++;
        if (o !== e.exp) begin
          miscompares++; $display("FAIL br%0d %s: got %h want %h", k, names[e.st], o, e.exp);
        end
        vectors++;
        if (!onehot0(o)) begin miscompares++; $display("FAIL br bus_enables: got %h want one-hot-or-zero", o); end
        @(negedge clk);
      end
    end
    N = 1'b0; Z = 1'b0; P = 1'b0;
  endtask

  task automatic test_ldr_wait();
    IR = 16'h6642;
    apply_reset();
    push(S_F0, 1); push(S_F1, 1); push(S_F2, 0); push(S_DEC, 1); push(S_ADDR, 1);
    push(S_MR, 0); push(S_MR, 0); push(S_MR, 0); push(S_MR, 1); push(S_LDREG, 0); push(S_F0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); mem_rdy = e.rdy; #1;
      o = observe(); vectors++;
      if (o !== e.exp) begin
        miscompares++; $display("FAIL ldr %s: got %h want %h", names[e.st], o, e.exp);
      end
      vectors++;
      if (!onehot0(o)) begin miscompares++; $display("FAIL ldr bus_enables: got %h want one-hot-or-zero", o); end
      @(negedge clk);
    end
  endtask

  task automatic test_ldi();
    IR = 16'hA002;
    apply_reset();
    push(S_F0, 1); push(S_F1, 1); push(S_F2, 1); push(S_DEC, 1); push(S_ADDR, 1);
    push(S_MR, 1); push(S_IND, 1); push(S_MR2, 1); push(S_LDREG, 1); push(S_F0, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); mem_rdy = e.rdy; #1;
      o = observe(); vectors++;
      if (o !== e.exp) begin
        miscompares++; $display("FAIL ldi %s: got %h want %h", names[e.st], o, e.exp);
      end
      vectors++;
      if (!onehot0(o)) begin miscompares++; $display("FAIL ldi bus_enables: got %h want one-hot-or-zero", o); end
      @(negedge clk);
    end
  endtask

  task automatic test_jmp_lea();
    for (int k = 0; k < 2; k++) begin
      IR = (k == 0) ? 16'hC1C0 : 16'hE405;
      apply_reset();
      push(S_F0, 1); push(S_F1, 1); push(S_F2, 1); push(S_DEC, 1);
      push((k == 0) ? S_JMP : S_LEA, 1); push(S_F0, 1);
      while (sb.size() > 0) begin
        e = sb.pop_front(); mem_rdy = e.rdy; #1;
        o = observe(); vectors++;
        if (o !== e.exp) begin
          miscompares++; $display("FAIL jmp_lea %s: got %h want %h", names[e.st], o, e.exp);
        end
        vectors++;
        if (!onehot0(o)) begin miscompares++; $display("FAIL jmp_lea bus_enables: got %h want one-hot-or-zero", o); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_halt();
    IR = 16'hF025;
    apply_reset();
    push(S_F0, 1); push(S_F1, 1); push(S_F2, 1); push(S_DEC, 1);
    for (int i = 0; i < 22; i++) push(S_HALT, i[0]);
    while (sb.size() > 0) begin
      e = sb.pop_front(); mem_rdy = e.rdy; #1;
      o = observe(); vectors++;
      if (o !== e.exp) begin
        miscompares++; $display("FAIL halt %s: got %h want %h", names[e.st], o, e.exp);
      end
      vectors++;
      if (!onehot0(o)) begin miscompares++; $display("FAIL halt bus_enables: got %h want one-hot-or-zero", o); end
      @(negedge clk);
    end
    rst = 1'b1; #1;
    o = observe(); vectors++;
    if (o.halted !== 1'b0 || o !== '0) begin
      miscompares++; $display("FAIL halt_reset_clear: got %h want %h", o, obs_t'('0));
    end
    @(negedge clk) rst = 1'b0; #1;
    o = observe(); ex = exp_state(S_F0, IR, N, Z, P, mem_rdy); vectors++;
    if (o !== ex) begin
      miscompares++; $display("FAIL halt_after_reset FETCH0: got %h want %h", o, ex);
    end
  endtask

  task automatic test_reset_midread();
    IR = 16'h2005;
    apply_reset();
    push(S_F0, 1); push(S_F1, 1); push(S_F2, 1); push(S_DEC, 1); push(S_ADDR, 1); push(S_MR, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); mem_rdy = e.rdy; #1;
      o = observe(); vectors++;
      if (o !== e.exp) begin
        miscompares++; $display("FAIL midread %s: got %h want %h", names[e.st], o, e.exp);
      end
      vectors++;
      if (!onehot0(o)) begin miscompares++; $display("FAIL midread bus_enables: got %h want one-hot-or-zero", o); end
      @(negedge clk);
    end
    mem_rdy = 1'b0; rst = 1'b1; #1;
    o = observe(); vectors++;
    if (o !== '0) begin
      miscompares++; $display("FAIL midread_reset_outputs: got %h want %h", o, obs_t'('0));
    end
    @(negedge clk) rst = 1'b0; #1;
    o = observe(); ex = exp_state(S_F0, IR, N, Z, P, mem_rdy); vectors++;
    if (o !== ex) begin
      miscompares++; $display("FAIL midread_after_reset FETCH0: got %h want %h", o, ex);
    end
    @(negedge clk); mem_rdy = 1'b1; #1;
    o = observe(); ex = exp_state(S_F1, IR, N, Z, P, 1'b1); vectors++;
    if (o !== ex) begin
      miscompares++; $display("FAIL midread_after_reset FETCH1: got %h want %h", o, ex);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_br();
    test_ldr_wait();
    test_ldi();
    test_jmp_lea();
    test_halt();
    test_reset_midread();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
